btn_event_ctrl: RTL and testbench

//  Scheduler for N active-low board buttons: one shared sample-tick timer serves every channel.

---
 rtl/btn_evt_pkg.sv | 29 ++
 rtl/btn_event_ctrl_chan.sv | 105 ++++++++++
 rtl/btn_event_ctrl.sv | 107 ++++++++++
 tb/tb_btn_event_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event codes, channel FSM encoding and sizing helpers for the button event controller.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;
  localparam int unsigned N_EVT      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } btn_state_e;

  function automatic int unsigned tick_cycles(input int unsigned clk_hz, input int unsigned tick_ms);
    int unsigned cyc;
    cyc = (clk_hz / 1000) * tick_ms;
    return (cyc < 1) ? 1 : cyc;
  endfunction

  // Width able to hold 0..max(a,b)-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_event_ctrl_chan.sv
// One button channel: synchroniser, tick sampling, debounced level, press/hold FSM and pending flags.
module btn_evt_chan
  import btn_evt_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_n,
  input  logic       i_tick,
  input  logic [3:0] i_grant,
  output logic       o_level,
  output logic [3:0] o_pend,
  output logic       o_coll
);

  localparam int unsigned     HW       = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [HW-1:0]   LONG_END = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0]   REP_END  = HW'(REPEAT_TICKS - 1);

  logic [1:0]    r_sync;
  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  btn_state_e    r_state;
  logic [HW-1:0] r_hcnt;
  logic [3:0]    r_pend;
  logic          r_coll;
  logic [3:0]    w_raise;

  // Event conditions decoded from the current FSM state.
  always_comb begin
    w_raise = '0;
    case (r_state)
      ST_IDLE: if (r_level) w_raise[EVT_PRESS] = 1'b1;
      ST_DOWN: begin
        if (!r_level)                          w_raise[EVT_RELEASE] = 1'b1;
        else if (i_tick && r_hcnt == LONG_END) w_raise[EVT_LONG]    = 1'b1;
      end
      ST_HELD: begin
        if (!r_level)                         w_raise[EVT_RELEASE] = 1'b1;
        else if (i_tick && r_hcnt == REP_END) w_raise[EVT_REPEAT]  = 1'b1;
      end
      default: w_raise = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_pend  <= '0;
      r_coll  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], ~i_btn_n};
      if (i_tick) begin
        r_s1 <= r_sync[1];
        r_s2 <= r_s1;
        if (r_s1 == r_s2 && r_s1 != r_level) r_level <= r_s1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_level) begin
            r_state <= ST_DOWN;
            r_hcnt  <= '0;
          end
        end
        ST_DOWN: begin
          if (!r_level) begin
            r_state <= ST_IDLE;
          end else if (i_tick) begin
            if (r_hcnt == LONG_END) begin
              r_state <= ST_HELD;
              r_hcnt  <= '0;
            end else begin
              r_hcnt <= r_hcnt + HW'(1);
            end
          end
        end
        ST_HELD: begin
          if (!r_level) begin
            r_state <= ST_IDLE;
          end else if (i_tick) begin
            if (r_hcnt == REP_END) r_hcnt <= '0;
            else                   r_hcnt <= r_hcnt + HW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A re-raised flag that is not leaving this cycle means one event is lost.
      r_coll <= |(w_raise & r_pend & ~i_grant);
      r_pend <= (r_pend & ~i_grant) | w_raise;
    end
  end

  assign o_level = r_level;
  assign o_pend  = r_pend;
  assign o_coll  = r_coll;

endmodule

// File: rtl/btn_event_ctrl.sv
// N-button event controller: shared sample tick, per-channel classifiers, fixed-priority
// arbiter and a single valid/ready output slot with a sticky overflow flag.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned CLK_HZ       = 12_000_000,
  parameter int unsigned TICK_MS      = 20,
  parameter int unsigned LONG_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  localparam int unsigned IDW         = (N_BTN < 2) ? 1 : $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [1:0]       evt_code,
  output logic             evt_ovf
);

  localparam int unsigned   TICK_CYC = tick_cycles(CLK_HZ, TICK_MS);
  localparam int unsigned   TW       = (TICK_CYC < 2) ? 1 : $clog2(TICK_CYC);
  localparam logic [TW-1:0] TICK_END = TW'(TICK_CYC - 1);
  localparam int unsigned   NP       = N_BTN * N_EVT;
  localparam int unsigned   IW       = $clog2(NP);

  logic [TW-1:0]    r_tcnt;
  logic             w_tick;
  logic [NP-1:0]    w_pend;
  logic [NP-1:0]    w_grant;
  logic [N_BTN-1:0] w_coll;
  logic             w_load;
  logic             w_hit;
  logic [IW-1:0]    w_idx;
  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic [1:0]       r_code;
  logic             r_ovf;

  // Shared sample timer.
  always_ff @(posedge clk) begin
    if (rst)         r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else             r_tcnt <= r_tcnt + TW'(1);
  end

  assign w_tick = (r_tcnt == TICK_END);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_evt_chan #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_btn_n(btn_in[g]),
      .i_tick (w_tick),
      .i_grant(w_grant[g*N_EVT +: N_EVT]),
      .o_level(btn_level[g]),
      .o_pend (w_pend[g*N_EVT +: N_EVT]),
      .o_coll (w_coll[g])
    );
  end

  // Flat index is id*4+code, so the lowest set bit is the highest-priority event.
  assign w_load = !r_valid || evt_ready;

  always_comb begin
    w_hit   = 1'b0;
    w_idx   = '0;
    w_grant = '0;
    for (int i = int'(NP) - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
    if (w_load && w_hit) w_grant[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_hit;
        if (w_hit) begin
          r_id   <= IDW'(w_idx >> 2);
          r_code <= w_idx[1:0];
        end
      end
      if (|w_coll) r_ovf <= 1'b1;
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign evt_code  = r_code;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: a tick/hold-count reference model predicts every event.
module tb_btn_event_ctrl;

  localparam int unsigned NB = 4;
  localparam int          TC = 4;
  localparam int          L  = 5;
  localparam int          R  = 2;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] code;
  } evt_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_id;
  logic [1:0]    evt_code;
  logic          evt_ovf;

  int n_chk = 0;
  int n_err = 0;
  int acc_cnt = 0;
  evt_t sb[$];

  // Reference model state
  int m_cyc;
  bit m_d1 [NB];
  bit m_d2 [NB];
  bit m_sa [NB];
  bit m_sb [NB];
  bit m_lvl [NB];
  bit m_down [NB];
  int m_n [NB];
  bit m_pend [NB][4];
  bit m_valid;
  bit m_ovf;
  bit m_coll;

  btn_event_ctrl #(
    .N_BTN       (NB),
    .CLK_HZ      (1000),
    .TICK_MS     (4),
    .LONG_TICKS  (L),
    .REPEAT_TICKS(R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_code (evt_code),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a press counts ticks held; LONG at tick L, REPEAT every R ticks after that.
  always @(posedge clk) begin : model
    bit tick, load, hit, gr, collx;
    bit rz [4];
    int wc, wk;
    if (rst) begin
      m_cyc = 0; m_valid = 0; m_ovf = 0; m_coll = 0;
      sb.delete();
      for (int ch = 0; ch < NB; ch++) begin
        m_d1[ch] = 0; m_d2[ch] = 0; m_sa[ch] = 0; m_sb[ch] = 0;
        m_lvl[ch] = 0; m_down[ch] = 0; m_n[ch] = 0;
        for (int c = 0; c < 4; c++) m_pend[ch][c] = 0;
      end
    end else begin
      tick = (m_cyc % TC) == TC - 1;
      m_cyc++;
      load = !m_valid || evt_ready;
      hit = 0; wc = 0; wk = 0;
      for (int ch = NB - 1; ch >= 0; ch--)
        for (int c = 3; c >= 0; c--)
          if (m_pend[ch][c]) begin hit = 1; wc = ch; wk = c; end
      collx = 0;
      for (int ch = 0; ch < NB; ch++) begin
        for (int c = 0; c < 4; c++) rz[c] = 0;
        if (!m_down[ch] && m_lvl[ch]) begin
          rz[0] = 1; m_down[ch] = 1; m_n[ch] = 0;
        end else if (m_down[ch] && !m_lvl[ch]) begin
          rz[1] = 1; m_down[ch] = 0;
        end else if (m_down[ch] && tick) begin
          m_n[ch]++;
          if (m_n[ch] == L) rz[2] = 1;
          else if (m_n[ch] > L && (m_n[ch] - L) % R == 0) rz[3] = 1;
        end
        for (int c = 0; c < 4; c++) begin
          gr = load && hit && wc == ch && wk == c;
          if (rz[c] && m_pend[ch][c] && !gr) collx = 1;
          m_pend[ch][c] = (m_pend[ch][c] && !gr) || rz[c];
        end
        if (tick) begin
          if (m_sa[ch] == m_sb[ch] && m_sa[ch] != m_lvl[ch]) m_lvl[ch] = m_sa[ch];
          m_sb[ch] = m_sa[ch];
          m_sa[ch] = m_d2[ch];
        end
        m_d2[ch] = m_d1[ch];
        m_d1[ch] = !btn_in[ch];
      end
      if (m_coll) m_ovf = 1;
      m_coll = collx;
      if (load) begin
        m_valid = hit;
        if (hit) sb.push_back(evt_t'{id: 2'(wc), code: 2'(wk)});
      end
    end
  end

  // Monitor: compare outputs every cycle, pop the scoreboard on each handshake.
  always @(negedge clk) begin : monitor
    logic [NB-1:0] lv;
    for (int ch = 0; ch < NB; ch++) lv[ch] = m_lvl[ch];
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("btn_level", 32'(btn_level), 32'(lv));
    chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
    if (evt_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_empty: got id %0d code %0d expected no event at %0t", evt_id, evt_code, $time);
      end else begin
        chk("evt_id", 32'(evt_id), 32'(sb[0].id));
        chk("evt_code", 32'(evt_code), 32'(sb[0].code));
        if (evt_ready === 1'b1 && rst === 1'b0) begin
          void'(sb.pop_front());
          acc_cnt++;
        end
      end
    end
  end

  initial begin : stim
    int ch;
    rst = 1'b1;
    btn_in = '1;
    evt_ready = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_ovf", 32'(evt_ovf), 32'd0);
    chk("rst_id_code", 32'({evt_id, evt_code}), 32'd0);
    rst = 1'b0;
    cyc(100);
    chk("idle_no_event", 32'(acc_cnt), 32'd0);

    // Short press on button 2
    btn_in[2] = 1'b0;
    cyc(12);
    btn_in[2] = 1'b1;
    cyc(40);
    chk("short_press_events", 32'(acc_cnt), 32'd2);
    chk("short_press_ovf", 32'(evt_ovf), 32'd0);

    // Bouncy button 1
    for (int k = 0; k < 13; k++) begin
      btn_in[1] = ~btn_in[1];
      cyc(3);
    end
    btn_in[1] = 1'b1;
    cyc(40);

    // Long hold on button 0
    btn_in[0] = 1'b0;
    cyc(60);
    btn_in[0] = 1'b1;
    cyc(40);

    // Simultaneous press on buttons 3 and 0 with the consumer stalled
    evt_ready = 1'b0;
    btn_in[3] = 1'b0;
    btn_in[0] = 1'b0;
    cyc(20);
    chk("stall_valid", 32'(evt_valid), 32'd1);
    chk("stall_id", 32'(evt_id), 32'd0);
    chk("stall_code", 32'(evt_code), 32'd0);
    evt_ready = 1'b1;
    cyc(2);
    btn_in = '1;
    cyc(40);

    // Overflow: repeated press/release while stalled, then reset mid-hold
    evt_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      btn_in[0] = 1'b0;
      cyc(12);
      btn_in[0] = 1'b1;
      cyc(12);
    end
    cyc(8);
    chk("ovf_set", 32'(evt_ovf), 32'd1);
    btn_in[0] = 1'b0;
    cyc(20);
    chk("ovf_sticky", 32'(evt_ovf), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_valid", 32'(evt_valid), 32'd0);
    chk("midrst_ovf", 32'(evt_ovf), 32'd0);
    chk("midrst_level", 32'(btn_level), 32'd0);
    rst = 1'b0;
    btn_in = '1;
    evt_ready = 1'b1;
    cyc(20);

    // Randomised traffic with random back-pressure and one mid-run reset
    for (int k = 0; k < 60; k++) begin
      ch = int'($urandom_range(NB - 1, 0));
      btn_in[ch] = ~btn_in[ch];
      evt_ready = ($urandom_range(3, 0) != 0);
      if (k == 30) begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end
      cyc(int'($urandom_range(80, 1)));
    end

    btn_in = '1;
    evt_ready = 1'b1;
    cyc(200);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
